// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU opcode, arbiter state and width definitions
package fpu_pkg;

    localparam int FPU_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        MUL = 3'b010,
        DIV = 3'b011
    } fpu_op_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        QUIESCED
    } arb_state_t;

endpackage

// File: rtl/fpu_tag_fifo.sv
// fpu_tag_fifo: in-order FIFO of requester tags for operations in flight; pops on empty are ignored
module fpu_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                     clk_gated,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    output logic [TAG_W-1:0]         head_tag,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty    = count == '0;
    assign do_pop   = pop && !empty;
    assign head_tag = mem[rd_ptr];

    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !do_pop)
                count <= count + CW'(1);
            else if (!push && do_pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_gated) begin
        if (push)
            mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: round-robin arbiter sharing one pipelined FPU among NUM_REQ requesters
module fpu_req_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = FPU_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk_gated,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [3*NUM_REQ-1:0]          req_op,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
    output logic                          fpu_valid_in,
    output logic [2:0]                    fpu_operation,
    output logic [DATA_WIDTH-1:0]         fpu_operand_a,
    output logic [DATA_WIDTH-1:0]         fpu_operand_b,
    input  logic                          fpu_valid_out,
    input  logic [DATA_WIDTH-1:0]         fpu_result,
    input  logic                          fpu_exception,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          rsp_exception,
    input  logic                          quiesce,
    output logic                          idle,
    output logic                          err_orphan
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int CW    = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [TAG_W-1:0] last_grant;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W-1:0] cand;
    logic [TAG_W-1:0] head_tag;
    logic [CW-1:0]    count;
    logic             grant_any;
    logic             can_grant;
    logic             xfer;
    logic             empty;

    // Scan downward so the lowest offset from last_grant+1 is written last and wins
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = TAG_W'((int'(last_grant) + 1 + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_idx = cand;
                grant_any = 1'b1;
            end
        end
    end

    assign can_grant = (state == RUN) && (count < CW'(MAX_OUTSTANDING));
    assign xfer      = can_grant && grant_any;

    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      state_nxt = quiesce ? DRAIN : RUN;
            DRAIN:    state_nxt = !quiesce ? RUN : (count == '0 && !fpu_valid_in) ? QUIESCED : DRAIN;
            QUIESCED: state_nxt = quiesce ? QUIESCED : RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        req_ready = xfer ? NUM_REQ'(1) << grant_idx : '0;
        idle      = state == QUIESCED;
    end

    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= TAG_W'(NUM_REQ - 1);
            fpu_valid_in  <= 1'b0;
            fpu_operation <= '0;
            fpu_operand_a <= '0;
            fpu_operand_b <= '0;
            err_orphan    <= 1'b0;
        end else begin
            fpu_valid_in <= xfer;
            if (xfer) begin
                last_grant    <= grant_idx;
                fpu_operation <= req_op[grant_idx*3 +: 3];
                fpu_operand_a <= req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                fpu_operand_b <= req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (fpu_valid_out && empty)
                err_orphan <= 1'b1;
        end
    end

    // Results return in issue order, so the FIFO head names the owner
    assign rsp_valid     = (fpu_valid_out && !empty) ? NUM_REQ'(1) << head_tag : '0;
    assign rsp_result    = fpu_result;
    assign rsp_exception = fpu_exception;

    fpu_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk_gated (clk_gated),
        .rst_n     (rst_n),
        .push      (xfer),
        .push_tag  (grant_idx),
        .pop       (fpu_valid_out),
        .head_tag  (head_tag),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb_fpu_req_arbiter: directed checks of the FPU request arbiter against an XOR FPU model
module tb_fpu_req_arbiter;
    import fpu_pkg::*;

    logic         clk_gated;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [11:0]  req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         fpu_valid_in;
    logic [2:0]   fpu_operation;
    logic [31:0]  fpu_operand_a;
    logic [31:0]  fpu_operand_b;
    logic         fpu_valid_out;
    logic [31:0]  fpu_result;
    logic         fpu_exception;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_result;
    logic         rsp_exception;
    logic         quiesce;
    logic         idle;
    logic         err_orphan;

    logic [2:0]   op_v [4];
    logic [31:0]  a_v  [4];
    logic [31:0]  b_v  [4];
    logic [7:0]   pv;
    logic [7:0]   pe;
    logic [31:0]  pd   [8];
    logic         spur;
    int           lat;
    int           total;
    int           passed;

    fpu_req_arbiter dut (
        .clk_gated     (clk_gated),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .fpu_valid_in  (fpu_valid_in),
        .fpu_operation (fpu_operation),
        .fpu_operand_a (fpu_operand_a),
        .fpu_operand_b (fpu_operand_b),
        .fpu_valid_out (fpu_valid_out),
        .fpu_result    (fpu_result),
        .fpu_exception (fpu_exception),
        .rsp_valid     (rsp_valid),
        .rsp_result    (rsp_result),
        .rsp_exception (rsp_exception),
        .quiesce       (quiesce),
        .idle          (idle),
        .err_orphan    (err_orphan)
    );

    initial clk_gated = 1'b0;
    always #5 clk_gated = ~clk_gated;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_op[3*i +: 3] = op_v[i];
            req_a[32*i +: 32] = a_v[i];
            req_b[32*i +: 32] = b_v[i];
        end
    end

    // FPU model: fixed latency, result = a ^ b, exception for opcodes 1xx
    always @(posedge clk_gated) begin
        pv <= {pv[6:0], fpu_valid_in};
        pe <= {pe[6:0], fpu_operation[2]};
        pd[0] <= fpu_operand_a ^ fpu_operand_b;
        for (int i = 7; i > 0; i--)
            pd[i] <= pd[i-1];
    end

    assign fpu_valid_out = pv[lat-1] | spur;
    assign fpu_result    = pd[lat-1];
    assign fpu_exception = pe[lat-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic nxt;
        @(posedge clk_gated);
        #1;
    endtask

    task automatic smp;
        @(negedge clk_gated);
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        quiesce   = 1'b0;
        spur      = 1'b0;
        repeat (3) @(posedge clk_gated);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction

    int          seq [5] = '{0, 1, 2, 3, 0};
    int          r4  [11] = '{1, 2, 4, 8, 0, 0, 0, 0, 1, 2, 4};
    logic [3:0]  e;

    initial begin
        total  = 0;
        passed = 0;
        lat    = 2;
        for (int i = 0; i < 4; i++) begin
            op_v[i] = '0;
            a_v[i]  = '0;
            b_v[i]  = '0;
        end
        rst_n     = 1'b0;
        req_valid = '0;
        quiesce   = 1'b0;
        spur      = 1'b0;
        repeat (2) @(posedge clk_gated);
        smp;
        check("rst_ready", req_ready, 0);
        check("rst_vin", fpu_valid_in, 0);
        check("rst_op", fpu_operation, 0);
        check("rst_a", fpu_operand_a, 0);
        check("rst_b", fpu_operand_b, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_err", err_orphan, 0);
        check("rst_idle", idle, 0);

        // Single request from requester 2
        do_reset;
        op_v[2] = ADD;
        a_v[2] = 32'h3F80_0000;
        b_v[2] = 32'h4000_0000;
        req_valid = 4'b0100;
        smp;
        check("one_ready", req_ready, 4'b0100);
        nxt;
        req_valid = '0;
        smp;
        check("one_vin", fpu_valid_in, 1);
        check("one_op", fpu_operation, ADD);
        check("one_a", fpu_operand_a, 32'h3F80_0000);
        check("one_b", fpu_operand_b, 32'h4000_0000);
        nxt;
        smp;
        check("one_vin_low", fpu_valid_in, 0);
        check("one_rsp_early", rsp_valid, 0);
        nxt;
        smp;
        check("one_rsp", rsp_valid, 4'b0100);
        check("one_res", rsp_result, 32'h7F80_0000);
        check("one_exc", rsp_exception, 0);
        nxt;
        smp;
        check("one_rsp_end", rsp_valid, 0);

        // All requesters continuously valid
        op_v = '{ADD, SUB, MUL, 3'b101};
        a_v  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        b_v  = '{32'h0000_FFFF, 32'h00FF_00FF, 32'h0F0F_0F0F, 32'h5555_5555};
        do_reset;
        for (int c = 0; c < 8; c++) begin
            req_valid = c < 5 ? 4'hF : 4'h0;
            smp;
            e = c < 5 ? oh(seq[c]) : 4'h0;
            check("rr_ready", req_ready, e);
            if (c >= 1 && c <= 5)
                check("rr_op", fpu_operation, op_v[seq[c-1]]);
            e = c >= 3 ? oh(seq[c-3]) : 4'h0;
            check("rr_rsp", rsp_valid, e);
            if (c >= 3) begin
                check("rr_res", rsp_result, a_v[seq[c-3]] ^ b_v[seq[c-3]]);
                check("rr_exc", rsp_exception, op_v[seq[c-3]][2]);
            end
            nxt;
        end

        // Outstanding limit with a 6-cycle FPU
        lat = 6;
        do_reset;
        for (int c = 0; c < 11; c++) begin
            req_valid = 4'hF;
            smp;
            check("lim_ready", req_ready, r4[c]);
            if (c >= 7)
                check("lim_rsp", rsp_valid, oh(c - 7));
            nxt;
        end
        req_valid = '0;
        repeat (12) nxt;

        // Quiesce with three operations in flight
        do_reset;
        for (int c = 0; c < 14; c++) begin
            req_valid = 4'hF;
            quiesce = c >= 2 && c < 12;
            smp;
            e = c < 3 ? oh(c) : c == 13 ? 4'b1000 : 4'h0;
            check("q_ready", req_ready, e);
            check("q_idle", idle, c == 11 || c == 12);
            if (c >= 7 && c <= 9)
                check("q_rsp", rsp_valid, oh(c - 7));
            nxt;
        end
        req_valid = '0;
        repeat (12) nxt;

        // Spurious FPU result with nothing in flight
        lat = 2;
        spur = 1'b1;
        smp;
        check("orph_rsp", rsp_valid, 0);
        nxt;
        spur = 1'b0;
        smp;
        check("orph_set", err_orphan, 1);
        repeat (3) nxt;
        smp;
        check("orph_sticky", err_orphan, 1);
        nxt;
        rst_n = 1'b0;
        #1;
        check("orph_async_clr", err_orphan, 0);
        do_reset;

        // Reset while an operation is in flight
        req_valid = 4'b0010;
        smp;
        check("mid_ready", req_ready, 4'b0010);
        nxt;
        req_valid = '0;
        smp;
        check("mid_vin", fpu_valid_in, 1);
        nxt;
        rst_n = 1'b0;
        smp;
        check("mid_vin_rst", fpu_valid_in, 0);
        nxt;
        rst_n = 1'b1;
        smp;
        check("mid_rsp", rsp_valid, 0);
        nxt;
        smp;
        check("mid_err", err_orphan, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
